// File: rtl/mod_exp_sequencer.sv
// mod_exp_sequencer
//   Left-to-right square-and-multiply controller computing
//   base^exponent mod modulus. Arithmetic is delegated to an external
//   modular multiplier over an AXI-stream request/result pair.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   input_base_*                  AXI-stream slave, base operand
//   input_exponent_*              AXI-stream slave, exponent
//   input_modulus_*               AXI-stream slave, modulus
//   mul_multiplier/multiplicand   request operands A/B
//   mul_modulus_tdata             {SIZE zeros, modulus}
//   mul_req_tvalid/tready         request handshake
//   mul_result_*                  reduced product from the multiplier
//   output_*                      AXI-stream master, final result
module mod_exp_sequencer #(
  parameter int unsigned SIZE = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SIZE-1:0]     input_base_tdata,
  input  logic                input_base_tvalid,
  output logic                input_base_tready,
  input  logic [SIZE-1:0]     input_exponent_tdata,
  input  logic                input_exponent_tvalid,
  output logic                input_exponent_tready,
  input  logic [SIZE-1:0]     input_modulus_tdata,
  input  logic                input_modulus_tvalid,
  output logic                input_modulus_tready,
  output logic [SIZE-1:0]     mul_multiplier_tdata,
  output logic [SIZE-1:0]     mul_multiplicand_tdata,
  output logic [2*SIZE-1:0]   mul_modulus_tdata,
  output logic                mul_req_tvalid,
  input  logic                mul_req_tready,
  input  logic [2*SIZE-1:0]   mul_result_tdata,
  input  logic                mul_result_tvalid,
  output logic                mul_result_tready,
  output logic [SIZE-1:0]     output_tdata,
  output logic                output_tvalid,
  input  logic                output_tready
);

  localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SQ_REQ   = 3'd1;
  localparam logic [2:0] S_SQ_WAIT  = 3'd2;
  localparam logic [2:0] S_MUL_REQ  = 3'd3;
  localparam logic [2:0] S_MUL_WAIT = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]      r_state, w_state_nxt;
  logic [SIZE-1:0] r_acc, w_acc_nxt;
  logic [SIZE-1:0] r_base, w_base_nxt;
  logic [SIZE-1:0] r_exp, w_exp_nxt;
  logic [SIZE-1:0] r_mod, w_mod_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [SIZE-1:0] r_req_b, w_req_b_nxt;
  logic            r_req_valid, w_req_valid_nxt;
  logic            r_res_ready, w_res_ready_nxt;
  logic            r_out_valid, w_out_valid_nxt;

  logic            w_in_ready;
  logic            w_req_fire;
  logic            w_res_fire;
  logic            w_advance;
  logic [SIZE-1:0] w_res_low;
  logic            w_unused_res_hi;

  // Operands are taken only on a joint handshake of all three channels.
  assign w_in_ready = (r_state == S_IDLE) && input_base_tvalid
                      && input_exponent_tvalid && input_modulus_tvalid;
  assign input_base_tready     = w_in_ready;
  assign input_exponent_tready = w_in_ready;
  assign input_modulus_tready  = w_in_ready;

  assign w_req_fire      = r_req_valid && mul_req_tready;
  assign w_res_fire      = r_res_ready && mul_result_tvalid;
  assign w_res_low       = mul_result_tdata[SIZE-1:0];
  assign w_unused_res_hi = ^mul_result_tdata[2*SIZE-1:SIZE];

  // Operand A is always the running accumulator; B is r or base.
  assign mul_multiplier_tdata   = r_acc;
  assign mul_multiplicand_tdata = r_req_b;
  assign mul_modulus_tdata      = {{SIZE{1'b0}}, r_mod};
  assign mul_req_tvalid         = r_req_valid;
  assign mul_result_tready      = r_res_ready;
  assign output_tdata           = r_acc;
  assign output_tvalid          = r_out_valid;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_base_nxt      = r_base;
    w_exp_nxt       = r_exp;
    w_mod_nxt       = r_mod;
    w_idx_nxt       = r_idx;
    w_req_b_nxt     = r_req_b;
    w_req_valid_nxt = r_req_valid;
    w_res_ready_nxt = r_res_ready;
    w_out_valid_nxt = r_out_valid;
    w_advance       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_in_ready) begin
          w_base_nxt = input_base_tdata;
          w_exp_nxt  = input_exponent_tdata;
          w_mod_nxt  = input_modulus_tdata;
          w_idx_nxt  = IDX_W'(SIZE - 1);
          // Modulus 0 or 1: result is 0, multiplier is never used.
          if (input_modulus_tdata < SIZE'(2)) begin
            w_acc_nxt       = '0;
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = S_DONE;
          end else begin
            w_acc_nxt       = SIZE'(1);
            w_req_b_nxt     = SIZE'(1);
            w_req_valid_nxt = 1'b1;
            w_state_nxt     = S_SQ_REQ;
          end
        end
      end
      S_SQ_REQ, S_MUL_REQ: begin
        if (w_req_fire) begin
          w_req_valid_nxt = 1'b0;
          w_res_ready_nxt = 1'b1;
          w_state_nxt     = (r_state == S_SQ_REQ) ? S_SQ_WAIT : S_MUL_WAIT;
        end
      end
      S_SQ_WAIT: begin
        if (w_res_fire) begin
          w_acc_nxt       = w_res_low;
          w_res_ready_nxt = 1'b0;
          if (r_exp[r_idx]) begin
            w_req_b_nxt     = r_base;
            w_req_valid_nxt = 1'b1;
            w_state_nxt     = S_MUL_REQ;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      S_MUL_WAIT: begin
        if (w_res_fire) begin
          w_acc_nxt       = w_res_low;
          w_res_ready_nxt = 1'b0;
          w_advance       = 1'b1;
        end
      end
      S_DONE: begin
        if (r_out_valid && output_tready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_req_valid_nxt = 1'b0;
        w_res_ready_nxt = 1'b0;
        w_out_valid_nxt = 1'b0;
      end
    endcase

    // Bit-step folded into the wait-state exit: next square or finish.
    if (w_advance) begin
      if (r_idx == '0) begin
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_DONE;
      end else begin
        w_idx_nxt       = r_idx - IDX_W'(1);
        w_req_b_nxt     = w_res_low;
        w_req_valid_nxt = 1'b1;
        w_state_nxt     = S_SQ_REQ;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_base      <= '0;
      r_exp       <= '0;
      r_mod       <= '0;
      r_idx       <= '0;
      r_req_b     <= '0;
      r_req_valid <= 1'b0;
      r_res_ready <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_base      <= w_base_nxt;
      r_exp       <= w_exp_nxt;
      r_mod       <= w_mod_nxt;
      r_idx       <= w_idx_nxt;
      r_req_b     <= w_req_b_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_res_ready <= w_res_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_mod_exp_sequencer.sv
// tb_mod_exp_sequencer
//   Bench for mod_exp_sequencer at SIZE=16 with a 3-cycle multiplier model.
module tb_mod_exp_sequencer;

  localparam int unsigned W = 16;

  logic           clk;
  logic           rst;
  logic [W-1:0]   base_d, exp_d, mod_d;
  logic           base_v, exp_v, mod_v;
  logic           base_r, exp_r, mod_r;
  logic [W-1:0]   mul_a, mul_b;
  logic [2*W-1:0] mul_m;
  logic           mul_req_tvalid, mul_req_tready;
  logic [2*W-1:0] m_res_data;
  logic           m_res_valid, stray_valid, mul_result_tvalid, mul_result_tready;
  logic [W-1:0]   output_tdata;
  logic           output_tvalid, output_tready;

  mod_exp_sequencer #(.SIZE(W)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .input_base_tdata      (base_d),
    .input_base_tvalid     (base_v),
    .input_base_tready     (base_r),
    .input_exponent_tdata  (exp_d),
    .input_exponent_tvalid (exp_v),
    .input_exponent_tready (exp_r),
    .input_modulus_tdata   (mod_d),
    .input_modulus_tvalid  (mod_v),
    .input_modulus_tready  (mod_r),
    .mul_multiplier_tdata  (mul_a),
    .mul_multiplicand_tdata(mul_b),
    .mul_modulus_tdata     (mul_m),
    .mul_req_tvalid        (mul_req_tvalid),
    .mul_req_tready        (mul_req_tready),
    .mul_result_tdata      (m_res_data),
    .mul_result_tvalid     (mul_result_tvalid),
    .mul_result_tready     (mul_result_tready),
    .output_tdata          (output_tdata),
    .output_tvalid         (output_tvalid),
    .output_tready         (output_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fails;
  int cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: plain repeated multiplication, no bit scanning.
  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                               input logic [W-1:0] m);
    longint unsigned acc;
    if (m < 2) return '0;
    acc = 1;
    for (int k = 0; k < int'(e); k++) acc = (acc * longint'(b)) % longint'(m);
    return W'(acc);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: 3-cycle latency, random junk in the upper half.
  int           req_stall;
  int           stall_cfg;
  bit           pending;
  int           lat;
  logic [W-1:0] m_mod, last_r, prod;
  int           req_cnt, res_cnt, in_hs_cyc, last_res_cyc, last_req_cyc;

  assign mul_req_tready    = (req_stall == 0);
  assign mul_result_tvalid = m_res_valid | stray_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_res_valid <= 1'b0;
      m_res_data  <= '0;
      req_stall   <= 0;
      pending      = 1'b0;
      lat          = 0;
    end else begin
      if (base_v && exp_v && mod_v && base_r && exp_r && mod_r) begin
        m_mod     = mod_d;
        last_r    = W'(1);
        req_cnt   = 0;
        res_cnt   = 0;
        in_hs_cyc = cyc;
        req_stall <= stall_cfg;
      end else if (mul_req_tvalid && req_stall > 0) begin
        req_stall <= req_stall - 1;
      end
      if (m_res_valid && mul_result_tready) begin
        m_res_valid <= 1'b0;
        pending      = 1'b0;
        last_r       = m_res_data[W-1:0];
        res_cnt++;
        last_res_cyc = cyc;
      end
      if (mul_req_tvalid && mul_req_tready) begin
        prod         = W'((32'(mul_a) * 32'(mul_b)) % 32'(m_mod));
        pending      = 1'b1;
        lat          = 3;
        req_cnt++;
        last_req_cyc = cyc;
      end else if (pending && !m_res_valid) begin
        if (lat <= 1) begin
          m_res_valid <= 1'b1;
          m_res_data  <= {W'($urandom), prod};
        end else begin
          lat--;
        end
      end
    end
  end

  // Protocol monitor, sampled on the falling edge.
  bit           kinds[$];
  bit           kind;
  logic [W-1:0] cur_base;
  int           sq_cnt, mul_cnt;
  logic         p_req_valid, p_req_ready, p_out_valid, p_out_ready;
  logic [W-1:0] p_a, p_b, p_out;
  logic [2*W-1:0] p_m;

  always @(negedge clk) begin
    if (rst) begin
      kinds.delete();
    end else begin
      if (base_v && exp_v && mod_v && base_r && exp_r && mod_r) begin
        kinds.delete();
        sq_cnt   = 0;
        mul_cnt  = 0;
        cur_base = base_d;
        if (mod_d >= 2) begin
          for (int i = W - 1; i >= 0; i--) begin
            kinds.push_back(1'b0);
            if (exp_d[i]) kinds.push_back(1'b1);
          end
        end
      end
      if (mul_req_tvalid && mul_req_tready) begin
        check("one_outstanding", 64'(pending), 64'(0));
        check("req_modulus", 64'(mul_m), 64'(m_mod));
        check("req_expected", 64'(kinds.size() > 0), 64'(1));
        if (kinds.size() > 0) begin
          kind = kinds.pop_front();
          if (!kind) begin
            check("sq_operands", 64'({mul_a, mul_b}), 64'({last_r, last_r}));
            sq_cnt++;
          end else begin
            check("mul_operands", 64'({mul_a, mul_b}), 64'({last_r, cur_base}));
            mul_cnt++;
          end
        end
      end
      if (p_req_valid && !p_req_ready)
        check("req_hold", 64'({mul_req_tvalid, mul_a, mul_b}), 64'({1'b1, p_a, p_b}));
      if (p_req_valid && !p_req_ready)
        check("req_mod_hold", 64'(mul_m), 64'(p_m));
      if (p_out_valid && !p_out_ready)
        check("out_hold", 64'({output_tvalid, output_tdata}), 64'({1'b1, p_out}));
      if (mul_req_tvalid && !p_req_valid)
        check("req_latency", 64'(cyc), 64'((res_cnt == 0) ? in_hs_cyc + 1 : last_res_cyc + 1));
      if (cyc == last_req_cyc + 1)
        check("req_drop", 64'(mul_req_tvalid), 64'(0));
      if (output_tvalid && !p_out_valid)
        check("out_latency", 64'(cyc), 64'((req_cnt == 0) ? in_hs_cyc + 1 : last_res_cyc + 1));
    end
    p_req_valid = mul_req_tvalid;
    p_req_ready = mul_req_tready;
    p_out_valid = output_tvalid;
    p_out_ready = output_tready;
    p_a   = mul_a;
    p_b   = mul_b;
    p_m   = mul_m;
    p_out = output_tdata;
  end

  task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                        input int rstall, input int ostall, input int lone);
    logic [W-1:0] expv;
    int nreq;
    int t;
    expv = ref_modexp(b, e, m);
    nreq = (m < 2) ? 0 : int'(W) + $countones(e);
    @(posedge clk); #1;
    stall_cfg = rstall;
    output_tready = 1'b0;
    base_d = b; exp_d = e; mod_d = m;
    base_v = 1'b1; exp_v = 1'b1; mod_v = (lone == 0);
    for (int k = 0; k < lone; k++) begin
      @(negedge clk);
      check("lone_tready", 64'({base_r, exp_r, mod_r}), 64'(0));
    end
    if (lone > 0) begin
      @(posedge clk); #1;
      mod_v = 1'b1;
    end
    t = 0;
    @(negedge clk);
    while (!(base_r && exp_r && mod_r) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("joint_tready", 64'({base_r, exp_r, mod_r}), 64'(3'b111));
    // Valids stay high during the run; treadys must stay low.
    @(negedge clk);
    if (m < 2) begin
      check("short_out_valid", 64'(output_tvalid), 64'(1));
      check("short_no_req", 64'(mul_req_tvalid), 64'(0));
    end else begin
      check("first_req_valid", 64'(mul_req_tvalid), 64'(1));
    end
    check("busy_tready", 64'({base_r, exp_r, mod_r}), 64'(0));
    t = 0;
    while (!output_tvalid && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("out_valid_seen", 64'(output_tvalid), 64'(1));
    check("out_data", 64'(output_tdata), 64'(expv));
    check("req_count", 64'(req_cnt), 64'(nreq));
    check("done_tready", 64'({base_r, exp_r, mod_r}), 64'(0));
    repeat (ostall) @(negedge clk);
    @(posedge clk); #1;
    output_tready = 1'b1;
    base_v = 1'b0; exp_v = 1'b0; mod_v = 1'b0;
    @(posedge clk); #1;
    output_tready = 1'b0;
    @(negedge clk);
    check("out_released", 64'(output_tvalid), 64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    n_checks = 0; n_fails = 0; cyc = 0;
    rst = 1'b1;
    base_d = '0; exp_d = '0; mod_d = '0;
    base_v = 1'b0; exp_v = 1'b0; mod_v = 1'b0;
    output_tready = 1'b0; stray_valid = 1'b0; stall_cfg = 0;
    last_req_cyc = -10; in_hs_cyc = 0; last_res_cyc = 0; req_cnt = 0; res_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 64'({base_r, exp_r, mod_r, mul_req_tvalid, mul_result_tready, output_tvalid}), 64'(0));
    check("rst_data", 64'({mul_a, mul_b, output_tdata}), 64'(0));
    check("rst_mod", 64'(mul_m), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(16'd4, 16'd13, 16'd497, 0, 0, 0);
    check("e13_squares", 64'(sq_cnt), 64'(16));
    check("e13_mults", 64'(mul_cnt), 64'(3));

    run_op(16'd5, 16'd0, 16'd23, 0, 0, 0);
    check("e0_squares", 64'(sq_cnt), 64'(16));
    check("e0_mults", 64'(mul_cnt), 64'(0));

    run_op(W'($urandom), W'($urandom), 16'd1, 0, 0, 0);
    run_op(W'($urandom), W'($urandom), 16'd0, 0, 2, 0);

    run_op(16'd1000, 16'd2, 16'd497, 5, 10, 0);

    // Abandon an operation after its 4th request handshake.
    @(posedge clk); #1;
    stall_cfg = 0;
    base_d = 16'd4; exp_d = 16'd13; mod_d = 16'd497;
    base_v = 1'b1; exp_v = 1'b1; mod_v = 1'b1;
    @(posedge clk); #1;
    base_v = 1'b0; exp_v = 1'b0; mod_v = 1'b0;
    t = 0;
    @(negedge clk);
    while (req_cnt < 4 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("reached_4_reqs", 64'(req_cnt), 64'(4));
    #1 rst = 1'b1;
    #1;
    check("midrst_ctrl", 64'({base_r, exp_r, mod_r, mul_req_tvalid, mul_result_tready, output_tvalid}), 64'(0));
    check("midrst_data", 64'({mul_a, mul_b, output_tdata}), 64'(0));
    check("midrst_mod", 64'(mul_m), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    stray_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stray_not_taken", 64'(mul_result_tready), 64'(0));
    end
    @(posedge clk); #1;
    stray_valid = 1'b0;

    run_op(16'd4, 16'd13, 16'd497, 0, 0, 0);

    run_op(W'($urandom), W'($urandom), W'($urandom_range(2, 65535)), 0, 0, 8);

    for (int n = 0; n < 6; n++)
      run_op(W'($urandom), W'($urandom), W'($urandom_range(2, 65535)),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mod_exp_sequencer.md
# mod_exp_sequencer

Left-to-right square-and-multiply controller that computes base^exponent mod modulus for the ElGamal datapath. It accepts operands on AXI-stream slave channels and drives an external modular multiplier (the `multiplication_modulo` block) through an AXI-stream master request channel and slave result channel. It then returns the SIZE-bit result on an AXI-stream master output. It is the initiator side of the multiplier interface and owns no arithmetic beyond operand muxing.

## Interface
- SIZE, 64, operand width in bits (base, exponent, modulus, result)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- input_base_tdata  input  SIZE  base operand
- input_base_tvalid / input_base_tready  input / output  1  base handshake
- input_exponent_tdata  input  SIZE  exponent
- input_exponent_tvalid / input_exponent_tready  input / output  1  exponent handshake
- input_modulus_tdata  input  SIZE  modulus
- input_modulus_tvalid / input_modulus_tready  input / output  1  modulus handshake
- mul_multiplier_tdata  output  SIZE  request operand A
- mul_multiplicand_tdata  output  SIZE  request operand B
- mul_modulus_tdata  output  2*SIZE  {SIZE zeros, modulus}
- mul_req_tvalid / mul_req_tready  output / input  1  request handshake, shared by all three request fields
- mul_result_tdata  input  2*SIZE  reduced product; only the low SIZE bits are used
- mul_result_tvalid / mul_result_tready  input / output  1  result handshake
- output_tdata  output  SIZE  base^exponent mod modulus
- output_tvalid / output_tready  output / input  1  result handshake

## Operation
- States:
  - IDLE: all three input treadys are asserted only when in IDLE and all three tvalids are high. Operands are captured on that single joint handshake. A lone valid channel is never consumed.
  - Capture: r := 1, bit index i := SIZE-1. If modulus < 2, go to DONE with r := 0 and issue no requests. Otherwise go to SQ_REQ.
  - SQ_REQ: request (r, r). Go to SQ_WAIT on the mul_req handshake.
  - SQ_WAIT: mul_result_tready = 1. On the result handshake, r := result[SIZE-1:0]. If exponent[i] = 1, go to MUL_REQ; otherwise go to NEXT.
  - MUL_REQ: request (r, base). Go to MUL_WAIT on the handshake.
  - MUL_WAIT: on the result handshake, r := result[SIZE-1:0], then go to NEXT.
  - NEXT: if i == 0, go to DONE; otherwise i := i-1 and go to SQ_REQ. NEXT is merged into the wait-state transition and costs no cycle.
  - DONE: output_tvalid = 1 and output_tdata = r. On the output handshake, go to IDLE.
- Always runs exactly SIZE iterations, with no leading-zero skipping. The number of requests is SIZE + popcount(exponent).
- Base ≥ modulus is legal because the multiplier reduces it. Exponent 0 yields 1 when modulus ≥ 2.
- The upper SIZE bits of mul_result_tdata are ignored.
- AXI rules:
  - mul_req_tvalid and all request data stay stable until mul_req_tready.
  - output_tvalid and output_tdata stay stable until output_tready.
  - mul_result_tready is low outside the WAIT states, so stray results are not consumed.
- Exactly one request is outstanding at any time.

## Timing
- Reset (asynchronous): state IDLE, every output 0. This includes all input treadys, mul_req_tvalid, mul_result_tready, output_tvalid, and all tdata outputs.
- Reset mid-operation: the operation is abandoned immediately. Any in-flight multiplier result is not accepted; the multiplier shares rst. The next operation after reset completes correctly.
- Operand handshake at cycle 0:
  - mul_req_tvalid is first high at cycle 1 (registered).
  - If modulus < 2, output_tvalid is high at cycle 1 instead.
- Result handshake at cycle k: the next mul_req_tvalid is high at k+1. After the last result, output_tvalid is high at k+1.
- Request tvalid drops in the cycle after its handshake. The request must not be re-issued.
- Input treadys are low from the capture cycle until output_tvalid drops following the output handshake.

## Test plan
All scenarios use SIZE=16 and a behavioural multiplier model with a 3-cycle result latency.
- Base 4, exponent 13, modulus 497 -> output 445; exactly 19 request handshakes; requests alternate (r,r) and (r,4) only at exponent bits 3, 2 and 0.
- Base 5, exponent 0, modulus 23 -> output 1 after exactly 16 square requests and no base multiplies.
- Modulus 1, any base and exponent -> output 0 at cycle 1; mul_req_tvalid is never asserted.
- Base 1000, exponent 2, modulus 497 -> output 36. Apply backpressure: hold mul_req_tready low 5 cycles on the first request, and output_tready low 10 cycles. Check request data and output_tdata stay stable while stalled and each valid is held.
- Assert rst after the 4th request handshake -> all outputs 0 in the same cycle. A late mul_result_tvalid is not accepted. Then base 4, exponent 13, modulus 497 -> 445.
- Drive only input_base_tvalid and input_exponent_tvalid for 8 cycles -> all input treadys stay 0. Then raise input_modulus_tvalid -> a single joint handshake occurs.
